// File: rtl/tomasulo_cdb_arb.sv
// rtl/tomasulo_cdb_arb.sv - round-robin Common Data Bus arbiter with per-unit holding registers
// Completion records park in one-entry holding registers; one is broadcast per cycle on a registered CDB.
module tomasulo_cdb_arb #(
  parameter int N = 4,
  parameter int W = 32,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_vld,
  input  logic [N*W-1:0]  req_data,
  output logic [N-1:0]    req_rdy,
  output logic            cdb_vld_r,
  output logic [W-1:0]    cdb_data_r,
  output logic [SW-1:0]   cdb_src_r,
  output logic [N-1:0]    hold_vld_r
);

  logic [N-1:0]          hold_vld_q, hold_vld_d;
  logic [N-1:0][W-1:0]   hold_data_q, hold_data_d;
  logic [SW-1:0]         ptr_q, ptr_d;
  logic                  cdb_vld_q, cdb_vld_d;
  logic [W-1:0]          cdb_data_q, cdb_data_d;
  logic [SW-1:0]         cdb_src_q, cdb_src_d;

  logic [N-1:0]          gnt;
  logic [SW-1:0]         gnt_idx;
  logic                  gnt_any;
  logic [SW:0]           scan_idx;

  // Rotating priority search starting at ptr_q; first occupied register wins.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, ptr_q} + (SW+1)'(k);
      if (scan_idx >= (SW+1)'(N)) begin
        scan_idx = scan_idx - (SW+1)'(N);
      end
      if (!gnt_any && hold_vld_q[scan_idx[SW-1:0]]) begin
        gnt_any  = 1'b1;
        gnt_idx  = scan_idx[SW-1:0];
        gnt[scan_idx[SW-1:0]] = 1'b1;
      end
    end
  end

  // A granted register drains this edge, so it may be refilled in the same cycle.
  assign req_rdy = ~hold_vld_q | gnt;

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        hold_vld_d[i] = 1'b0;
      end
      if (req_vld[i] && req_rdy[i]) begin
        hold_vld_d[i]  = 1'b1;
        hold_data_d[i] = req_data[i*W +: W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
    end
  end

  always_comb begin
    cdb_vld_d  = gnt_any;
    cdb_data_d = gnt_any ? hold_data_q[gnt_idx] : '0;
    cdb_src_d  = gnt_any ? gnt_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q  <= '0;
      hold_data_q <= '0;
      ptr_q       <= '0;
      cdb_vld_q   <= 1'b0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      ptr_q       <= ptr_d;
      cdb_vld_q   <= cdb_vld_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_vld_r  = cdb_vld_q;
  assign cdb_data_r = cdb_data_q;
  assign cdb_src_r  = cdb_src_q;
  assign hold_vld_r = hold_vld_q;

endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// tb/tb_tomasulo_cdb_arb.sv - scoreboard bench for tomasulo_cdb_arb
// Driver updates a reference model and queues expectations; a monitor pops and compares.
module tb_tomasulo_cdb_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_vld;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_rdy;
  logic          cdb_vld_r;
  logic [W-1:0]  cdb_data_r;
  logic [1:0]    cdb_src_r;
  logic [N-1:0]  hold_vld_r;

  tomasulo_cdb_arb #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .cdb_vld_r(cdb_vld_r), .cdb_data_r(cdb_data_r), .cdb_src_r(cdb_src_r),
    .hold_vld_r(hold_vld_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         chk_rdy;
    logic [3:0] rdy;
    logic       cvld;
    logic [7:0] cdata;
    logic [1:0] csrc;
    logic [3:0] hv;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference state: occupancy, held record and next-priority unit.
  bit       m_hv[N];
  bit [7:0] m_hd[N];
  int       m_ptr = 0;
  bit       first_cycle = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic drive(input bit r, input logic [3:0] v, input logic [31:0] d,
                       output logic [3:0] rdy_o);
    exp_t e;
    int g;
    @(negedge clk);
    rst = r;
    req_vld = v;
    req_data = d;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && m_hv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    for (int i = 0; i < N; i++) e.rdy[i] = !m_hv[i] || (g == i);
    e.chk_rdy = !first_cycle;
    first_cycle = 1'b0;
    if (r) begin
      for (int i = 0; i < N; i++) begin m_hv[i] = 0; m_hd[i] = 0; end
      m_ptr = 0;
      e.cvld = 0; e.cdata = 0; e.csrc = 0;
    end else begin
      e.cvld  = (g >= 0);
      e.cdata = (g >= 0) ? m_hd[g] : 8'h00;
      e.csrc  = (g >= 0) ? 2'(g) : 2'd0;
      if (g >= 0) begin m_hv[g] = 0; m_ptr = (g + 1) % N; end
      for (int i = 0; i < N; i++) begin
        if (v[i] && e.rdy[i]) begin m_hv[i] = 1; m_hd[i] = d[i*8 +: 8]; end
      end
    end
    for (int i = 0; i < N; i++) e.hv[i] = m_hv[i];
    exp_q.push_back(e);
    rdy_o = e.rdy;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0 && exp_q[0].chk_rdy) chk("req_rdy", 32'(req_rdy), 32'(exp_q[0].rdy));
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cdb_vld_r", 32'(cdb_vld_r), 32'(e.cvld));
        chk("cdb_data_r", 32'(cdb_data_r), 32'(e.cdata));
        chk("cdb_src_r", 32'(cdb_src_r), 32'(e.csrc));
        chk("hold_vld_r", 32'(hold_vld_r), 32'(e.hv));
      end
    end
  end

  initial begin : driver
    logic [3:0]  rdy;
    logic [3:0]  pv;
    logic [31:0] pd;
    rst = 1'b1;
    req_vld = '0;
    req_data = '0;
    drive(1, 4'b0000, 32'h0, rdy);
    drive(1, 4'b0000, 32'h0, rdy);

    // single record through an idle arbiter
    drive(0, 4'b0001, 32'h000000A5, rdy);
    repeat (4) drive(0, 4'b0000, 32'h0, rdy);

    // one unit streaming back to back
    for (int k = 0; k < 6; k++) drive(0, 4'b0100, 32'(8'h10 + k) << 16, rdy);
    repeat (3) drive(0, 4'b0000, 32'h0, rdy);

    // four-way collision from ptr 0
    drive(1, 4'b0000, 32'h0, rdy);
    drive(0, 4'b1111, 32'h33221100, rdy);
    repeat (6) drive(0, 4'b0000, 32'h0, rdy);

    // wrap: ptr lands on 3 with units 0 and 3 occupied
    drive(1, 4'b0000, 32'h0, rdy);
    drive(0, 4'b0100, 32'h00550000, rdy);
    drive(0, 4'b1001, 32'h440000BB, rdy);
    repeat (4) drive(0, 4'b0000, 32'h0, rdy);

    // unit 1 stalls while 0 and 2 saturate
    pv = 4'b0010;
    pd = 32'h00007000;
    for (int k = 0; k < 12; k++) begin
      pd[7:0] = 8'(8'h80 + k);
      pd[23:16] = 8'(8'hC0 + k);
      drive(0, pv | 4'b0101, pd, rdy);
      if (pv[1] && rdy[1]) begin
        if (pd[15:8] == 8'h71) pv[1] = 1'b0;
        else pd[15:8] = 8'h71;
      end
    end
    repeat (6) drive(0, 4'b0000, 32'h0, rdy);

    // reset with records parked and one on the bus
    drive(0, 4'b0111, 32'h00E2E1E0, rdy);
    drive(0, 4'b0001, 32'h000000E3, rdy);
    drive(1, 4'b0000, 32'h0, rdy);
    repeat (4) drive(0, 4'b0000, 32'h0, rdy);

    // randomized traffic; offers persist until accepted
    pv = '0;
    pd = '0;
    for (int k = 0; k < 400; k++) begin
      bit r;
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 45) begin
          pv[i] = 1'b1;
          pd[i*8 +: 8] = 8'($urandom);
        end
      end
      r = ($urandom_range(0, 99) == 0);
      drive(r, pv, pd, rdy);
      if (!r) pv = pv & ~rdy;
    end
    repeat (8) drive(0, 4'b0000, 32'h0, rdy);

    @(posedge clk);
    #5;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
